// File: rtl/pll_lock_seq.sv
// Sequences an iCE40 PLL through reset, lock wait and lock qualification; ready is registered, 2-cycle lock sync latency.
// Define PLL_LOCK_SEQ_STATS_EN to instantiate the saturating relock_count register (otherwise it reads 0).
module pll_lock_seq #(
  parameter int HOLD_CYCLES   = 16,
  parameter int LOCK_TIMEOUT  = 12000,
  parameter int STABLE_CYCLES = 1200,
  parameter int LOSS_FILT     = 4,
  parameter int CW            = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_lock,
  input  logic       relock_req,
  output logic       pll_resetb,
  output logic       ready,
  output logic [1:0] state,
  output logic [7:0] relock_count
);

  typedef enum logic [1:0] {
    HOLD      = 2'b00,
    WAIT_LOCK = 2'b01,
    STABLE    = 2'b10,
    RUN       = 2'b11
  } state_t;

  localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] LOSS_LAST    = CW'(LOSS_FILT - 1);

  state_t        st;
  logic [CW-1:0] cnt;
  logic          lock_m;
  logic          lock_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st         <= HOLD;
      cnt        <= '0;
      pll_resetb <= 1'b0;
      ready      <= 1'b0;
    end else if (relock_req) begin
      st         <= HOLD;
      cnt        <= '0;
      pll_resetb <= 1'b0;
      ready      <= 1'b0;
    end else begin
      case (st)
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            st         <= WAIT_LOCK;
            cnt        <= '0;
            pll_resetb <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            st  <= STABLE;
            cnt <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            st         <= HOLD;
            cnt        <= '0;
            pll_resetb <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STABLE: begin
          // A lock glitch only restarts qualification; the PLL is not reset.
          if (!lock_s) begin
            st  <= WAIT_LOCK;
            cnt <= '0;
          end else if (cnt == STABLE_LAST) begin
            st    <= RUN;
            cnt   <= '0;
            ready <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RUN: begin
          if (lock_s) begin
            cnt <= '0;
          end else if (cnt == LOSS_LAST) begin
            st         <= HOLD;
            cnt        <= '0;
            pll_resetb <= 1'b0;
            ready      <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          st  <= HOLD;
          cnt <= '0;
        end
      endcase
    end
  end

  assign state = st;

`ifdef PLL_LOCK_SEQ_STATS_EN
  logic       leave_run;
  logic [7:0] relock_cnt_q;

  // Mirrors every exit from RUN taken by the FSM, whether requested or from lock loss.
  assign leave_run = (st == RUN) && (relock_req || (!lock_s && cnt == LOSS_LAST));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      relock_cnt_q <= 8'd0;
    end else if (leave_run && relock_cnt_q != 8'hFF) begin
      relock_cnt_q <= relock_cnt_q + 8'd1;
    end
  end

  assign relock_count = relock_cnt_q;
`else
  assign relock_count = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_seq.sv
// Directed bench for pll_lock_seq: default-parameter instance for timing, small instance for relock saturation.
module tb_pll_lock_seq;

`ifdef PLL_LOCK_SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic       pll_lock;
  logic       relock_req;
  logic       pll_resetb;
  logic       ready;
  logic [1:0] state;
  logic [7:0] relock_count;

  logic       lock_b;
  logic       relock_b;
  logic       resetb_b;
  logic       ready_b;
  logic [1:0] state_b;
  logic [7:0] count_b;

  int n_cmp = 0;
  int n_err = 0;

  pll_lock_seq dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pll_lock     (pll_lock),
    .relock_req   (relock_req),
    .pll_resetb   (pll_resetb),
    .ready        (ready),
    .state        (state),
    .relock_count (relock_count)
  );

  pll_lock_seq #(
    .HOLD_CYCLES   (2),
    .LOCK_TIMEOUT  (8),
    .STABLE_CYCLES (4),
    .LOSS_FILT     (2),
    .CW            (8)
  ) dut_b (
    .clk          (clk),
    .reset_n      (reset_n),
    .pll_lock     (lock_b),
    .relock_req   (relock_b),
    .pll_resetb   (resetb_b),
    .ready        (ready_b),
    .state        (state_b),
    .relock_count (count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic wait_state(input logic [1:0] tgt, input int budget, input string tag);
    int n;
    n = 0;
    while (state !== tgt && n < budget) begin
      step(1);
      n++;
    end
    chk(tag, state, tgt);
  endtask

  function automatic logic [31:0] cnt_exp(input int k);
    if (!STATS) return 0;
    return (k > 255) ? 255 : k;
  endfunction

  initial begin
    reset_n    = 1'b0;
    pll_lock   = 1'b0;
    relock_req = 1'b0;
    lock_b     = 1'b1;
    relock_b   = 1'b0;
    step(2);
    chk("rst_state", state, 0);
    chk("rst_resetb", pll_resetb, 0);
    chk("rst_ready", ready, 0);
    chk("rst_count", relock_count, 0);

    // Power-up: 16-cycle hold, lock 5 cycles later, ready 1203 cycles after lock rise.
    reset_n = 1'b1;
    step(15);
    chk("hold_end_resetb", pll_resetb, 0);
    chk("hold_end_state", state, 0);
    step(1);
    chk("wait_resetb", pll_resetb, 1);
    chk("wait_state", state, 1);
    step(5);
    pll_lock = 1'b1;
    step(2);
    chk("sync_lat_state", state, 1);
    step(1);
    chk("stable_state", state, 2);
    step(1199);
    chk("pre_ready", ready, 0);
    step(1);
    chk("ready_rise", ready, 1);
    chk("run_state", state, 3);
    chk("run_count0", relock_count, 0);

    // RUN: 3-cycle drop filtered, 4-cycle drop is lock loss.
    pll_lock = 1'b0;
    step(3);
    pll_lock = 1'b1;
    step(4);
    chk("drop3_ready", ready, 1);
    chk("drop3_state", state, 3);
    pll_lock = 1'b0;
    step(4);
    pll_lock = 1'b1;
    step(1);
    chk("drop4_pre_ready", ready, 1);
    step(1);
    chk("drop4_ready", ready, 0);
    chk("drop4_state", state, 0);
    chk("drop4_resetb", pll_resetb, 0);
    chk("drop4_count", relock_count, cnt_exp(1));

    // relock_req while in RUN.
    wait_state(2'b11, 1500, "reach_run2");
    relock_req = 1'b1;
    step(1);
    relock_req = 1'b0;
    chk("req_run_state", state, 0);
    chk("req_run_ready", ready, 0);
    chk("req_run_resetb", pll_resetb, 0);
    chk("req_run_count", relock_count, cnt_exp(2));
    step(15);
    chk("req_run_hold_state", state, 0);
    step(1);
    chk("req_run_wait_state", state, 1);
    chk("req_run_wait_resetb", pll_resetb, 1);

    // One-cycle lock glitch at STABLE count 600.
    step(1);
    chk("glitch_stable", state, 2);
    step(600);
    chk("glitch_pre_ready", ready, 0);
    pll_lock = 1'b0;
    step(1);
    pll_lock = 1'b1;
    step(2);
    chk("glitch_state", state, 1);
    chk("glitch_resetb", pll_resetb, 1);
    step(1);
    chk("glitch_restable", state, 2);
    step(1199);
    chk("glitch_pre_ready2", ready, 0);
    step(1);
    chk("glitch_ready", ready, 1);

    // Lock lost for good, relock_req in WAIT_LOCK, then timeout retries.
    pll_lock = 1'b0;
    step(5);
    chk("loss_pre_state", state, 3);
    step(1);
    chk("loss_state", state, 0);
    chk("loss_count", relock_count, cnt_exp(3));
    step(16);
    chk("loss_wait", state, 1);
    relock_req = 1'b1;
    step(1);
    relock_req = 1'b0;
    chk("req_wait_state", state, 0);
    chk("req_wait_ready", ready, 0);
    chk("req_wait_count", relock_count, cnt_exp(3));
    step(15);
    chk("req_wait_hold", state, 0);
    step(1);
    chk("req_wait_resume", state, 1);
    for (int i = 1; i <= 24016; i++) begin
      step(1);
      chk("timeout_resetb", pll_resetb,
          ((i >= 12000 && i < 12016) || i >= 24016) ? 0 : 1);
      chk("timeout_ready", ready, 0);
    end
    chk("timeout_state", state, 0);
    chk("timeout_count", relock_count, cnt_exp(3));

    // Asynchronous reset mid-STABLE.
    pll_lock = 1'b1;
    wait_state(2'b10, 100, "reach_stable");
    step(100);
    chk("mid_stable_resetb", pll_resetb, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_state", state, 0);
    chk("async_resetb", pll_resetb, 0);
    chk("async_ready", ready, 0);
    chk("async_count", relock_count, 0);
    chk("async_b_ready", ready_b, 0);
    step(2);
    reset_n = 1'b1;

    // Small instance: 300 forced relocks from RUN.
    step(20);
    chk("b_run", state_b, 3);
    chk("b_count0", count_b, 0);
    for (int k = 1; k <= 300; k++) begin
      relock_b = 1'b1;
      step(1);
      relock_b = 1'b0;
      chk("b_req_state", state_b, 0);
      chk("b_count", count_b, cnt_exp(k));
      step(7);
      chk("b_rerun", state_b, 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pll_lock_seq.md
Name: pll_lock_seq

Overview:
- Power-up and recovery sequencer for the iCE40 SB_PLL40_CORE wrapper (RESET active-low, LOCK output).
- Runs on the board reference clock (12 MHz). Holds the PLL in reset, releases it, and qualifies LOCK.
- Asserts `ready` only after lock has been stable; re-sequences the PLL on lock loss or software request.
- `ready` feeds the system reset generator in the PLL output domain; that block owns the synchronizer.

Parameters:
- HOLD_CYCLES, 16: cycles `pll_resetb` is held low per reset attempt (min 2).
- LOCK_TIMEOUT, 12000: cycles allowed in WAIT_LOCK before retry (1 ms at 12 MHz).
- STABLE_CYCLES, 1200: consecutive synchronized-lock-high cycles required before `ready` (100 us).
- LOSS_FILT, 4: consecutive synchronized-lock-low cycles in RUN treated as lock loss (min 1).
- CW, 16: internal counter width; must hold max(HOLD_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).

Ports:
- clk  in  1  reference clock, also the PLL REFERENCECLK.
- reset_n  in  1  asynchronous active-low reset.
- pll_lock  in  1  PLL LOCK, asynchronous to clk.
- relock_req  in  1  single-cycle pulse; forces a full re-sequence.
- pll_resetb  out  1  to the PLL reset pin, active-low.
- ready  out  1  PLL locked and qualified.
- state  out  2  current state encoding, for debug.
- relock_count  out  8  saturating count of re-sequences after the first lock (see Optional Feature).

Behaviour:
- pll_lock passes through a 2-flop synchronizer. `lock_s` is the second flop. All decisions use `lock_s`, so there are 2 cycles of input latency.
- Asynchronous reset (reset_n=0):
  - state=HOLD (00), counter=0, pll_resetb=0, ready=0, relock_count=0.
  - Synchronizer flops clear to 0.
- HOLD (00):
  - pll_resetb=0, ready=0. Counter increments each cycle.
  - When counter==HOLD_CYCLES-1: clear counter, go to WAIT_LOCK. pll_resetb drives 1 from the next cycle.
- WAIT_LOCK (01):
  - pll_resetb=1, ready=0.
  - If lock_s=1: clear counter, go to STABLE.
  - Else counter increments. When counter==LOCK_TIMEOUT-1: clear counter, go to HOLD (timeout retry).
- STABLE (10):
  - pll_resetb=1, ready=0.
  - If lock_s=0: clear counter, go to WAIT_LOCK. No PLL reset; a glitch restarts qualification only.
  - Else counter increments. When counter==STABLE_CYCLES-1: clear counter, go to RUN.
- RUN (11):
  - pll_resetb=1, ready=1. Registered output, asserted the first cycle state==RUN.
  - Counter counts consecutive lock_s=0 cycles and clears whenever lock_s=1.
  - When the count reaches LOSS_FILT: go to HOLD; ready drops the same edge.
  - Low runs shorter than LOSS_FILT are ignored; ready stays 1.
- relock_req:
  - In any state, relock_req=1 forces HOLD with counter cleared next edge; ready=0 next cycle.
  - It has priority over all other transitions in the same cycle.
  - relock_req held high keeps the block in HOLD; HOLD timing restarts after it falls.
- relock_count increments on every RUN->HOLD transition (lock loss or request) and saturates at 255.
  - Timeout retries from WAIT_LOCK are not counted.
- Counter wrap is impossible by construction. Comparisons are against parameter-1 at CW bits.
- All outputs are registered; no combinational input-to-output paths.

Optional Feature:
- PLL_LOCK_SEQ_STATS_EN
  - Defined: relock_count behaves as described above.
  - Undefined: relock_count is tied to 8'd0 and its counter register is not instantiated. All other behaviour is identical.

Test Plan:
- Reset release, lock rises 5 cycles after pll_resetb=1, then stays high (defaults):
  - pll_resetb goes 1 after 16 cycles.
  - ready goes 1 exactly 2+1200 cycles after the lock rise (±1 for entry edge; bench pins the exact figure).
  - state sequence is 00,01,10,11.
- Lock never asserts:
  - pll_resetb pulses low for 16 cycles every 16+12000 cycles.
  - ready stays 0; relock_count stays 0.
- In STABLE, lock drops for 1 cycle at count 600:
  - state returns to 01; pll_resetb stays 1.
  - ready rises 1200 cycles after lock returns.
- In RUN:
  - A 3-cycle lock drop leaves ready=1.
  - A 4-cycle drop gives ready=0 and state=00 on the 4th synchronized low cycle; relock_count=1.
- relock_req pulse while in RUN and in WAIT_LOCK:
  - Next cycle state=00, ready=0, full HOLD of 16 cycles.
  - relock_count increments only for the pulse in RUN.
- reset_n asserted mid-STABLE:
  - All outputs reach reset values immediately, without waiting for a clock edge.
  - With the macro undefined, relock_count reads 0 throughout 300 forced relocks; with it defined, it saturates at 255.
